// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the arbiter and the
// single-word memory port. The arbiter uses the slave view; the environment
// driving requests and memory responses uses the master view.
interface mem_arbiter_if #(
    parameter int data_width    = 32,
    parameter int address_width = 32
);
    // fetch port
    logic                     i_req;
    logic [address_width-1:0] i_addr;
    logic [1:0]               i_access_size;
    logic                     i_gnt;
    logic                     i_rvalid;
    logic                     i_done;
    logic [data_width-1:0]    i_rdata;
    // data port
    logic                     d_req;
    logic                     d_rw;
    logic [address_width-1:0] d_addr;
    logic [data_width-1:0]    d_wdata;
    logic [1:0]               d_access_size;
    logic                     d_gnt;
    logic                     d_rvalid;
    logic                     d_wack;
    logic                     d_done;
    logic [data_width-1:0]    d_rdata;
    // memory port
    logic [address_width-1:0] mem_address;
    logic [data_width-1:0]    mem_data_in;
    logic [1:0]               mem_access_size;
    logic                     mem_rw;
    logic                     mem_enable;
    logic                     mem_busy;
    logic [data_width-1:0]    mem_data_out;

    modport master (
        output i_req, i_addr, i_access_size,
        input  i_gnt, i_rvalid, i_done, i_rdata,
        output d_req, d_rw, d_addr, d_wdata, d_access_size,
        input  d_gnt, d_rvalid, d_wack, d_done, d_rdata,
        input  mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
        output mem_busy, mem_data_out
    );

    modport slave (
        input  i_req, i_addr, i_access_size,
        output i_gnt, i_rvalid, i_done, i_rdata,
        input  d_req, d_rw, d_addr, d_wdata, d_access_size,
        output d_gnt, d_rvalid, d_wack, d_done, d_rdata,
        output mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
        input  mem_busy, mem_data_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a read-only fetch port and a read/write data port
// onto one single-word memory port. A granted burst is issued one word per
// accepted beat (IDLE -> BURST -> DONE -> IDLE); ties alternate fairly.
module mem_arbiter #(
    parameter int data_width    = 32,
    parameter int address_width = 32
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // Index of the final beat for a burst-size code (1/4/8/16 words).
    function automatic logic [3:0] last_beat_of(input logic [1:0] size);
        logic [3:0] last_beat;
        case (size)
            2'd0:    last_beat = 4'd0;
            2'd1:    last_beat = 4'd3;
            2'd2:    last_beat = 4'd7;
            2'd3:    last_beat = 4'd15;
            default: last_beat = 4'd0;
        endcase
        return last_beat;
    endfunction

    state_t                   state_r;
    state_t                   state_s;
    logic                     owner_r;
    logic                     last_grant_r;
    logic                     rw_r;
    logic                     rvalid_r;
    logic [address_width-1:0] base_r;
    logic [3:0]               last_beat_r;
    logic [3:0]               beat_index_r;

    logic                     grant_s;
    logic                     grant_port_s;
    logic                     accept_s;
    logic                     in_burst_s;
    logic                     active_s;
    logic [address_width-1:0] req_addr_s;
    logic [1:0]               req_size_s;
    logic                     req_rw_s;
    logic [address_width-1:0] beat_addr_s;

    // Next-state logic: arbitration in IDLE, beat acceptance in BURST.
    always_comb begin
        state_s      = state_r;
        grant_s      = 1'b0;
        grant_port_s = last_grant_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.i_req && bus.d_req) begin
                    grant_s      = 1'b1;
                    grant_port_s = ~last_grant_r;
                end else if (bus.d_req) begin
                    grant_s      = 1'b1;
                    grant_port_s = PORT_DATA;
                end else if (bus.i_req) begin
                    grant_s      = 1'b1;
                    grant_port_s = PORT_FETCH;
                end else begin
                    grant_s      = 1'b0;
                end
                if (grant_s) begin
                    state_s = BURST;
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                accept_s = ~bus.mem_busy;
                if (accept_s && (beat_index_r == last_beat_r)) begin
                    state_s = DONE;
                end else begin
                    state_s = BURST;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Select the command fields of the port being granted (fetch is always a read).
    always_comb begin
        req_addr_s = bus.i_addr;
        req_size_s = bus.i_access_size;
        req_rw_s   = 1'b1;
        if (grant_port_s == PORT_DATA) begin
            req_addr_s = bus.d_addr;
            req_size_s = bus.d_access_size;
            req_rw_s   = bus.d_rw;
        end else begin
            req_addr_s = bus.i_addr;
            req_size_s = bus.i_access_size;
            req_rw_s   = 1'b1;
        end
    end

    // State register plus latched transaction context and read-beat tracker.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= PORT_FETCH;
            last_grant_r <= PORT_FETCH;
            rw_r         <= 1'b0;
            rvalid_r     <= 1'b0;
            base_r       <= {address_width{1'b0}};
            last_beat_r  <= 4'd0;
            beat_index_r <= 4'd0;
        end else begin
            state_r  <= state_s;
            rvalid_r <= accept_s & rw_r;
            if (grant_s) begin
                owner_r      <= grant_port_s;
                last_grant_r <= grant_port_s;
                base_r       <= req_addr_s & ~{{(address_width-2){1'b0}}, 2'b11};
                rw_r         <= req_rw_s;
                last_beat_r  <= last_beat_of(req_size_s);
                beat_index_r <= 4'd0;
            end else if (accept_s) begin
                if (beat_index_r == last_beat_r) begin
                    beat_index_r <= 4'd0;
                end else begin
                    beat_index_r <= beat_index_r + 4'd1;
                end
            end else begin
                beat_index_r <= beat_index_r;
            end
        end
    end

    assign in_burst_s  = (state_r == BURST);
    assign active_s    = (state_r != IDLE);
    // Word address wraps naturally at the top of the address space.
    assign beat_addr_s = base_r + address_width'({beat_index_r, 2'b00});

    assign bus.i_gnt           = active_s & (owner_r == PORT_FETCH);
    assign bus.d_gnt           = active_s & (owner_r == PORT_DATA);
    assign bus.mem_enable      = in_burst_s;
    assign bus.mem_address     = in_burst_s ? beat_addr_s : {address_width{1'b0}};
    assign bus.mem_rw          = in_burst_s & rw_r;
    assign bus.mem_data_in     = (in_burst_s && !rw_r) ? bus.d_wdata : {data_width{1'b0}};
    assign bus.mem_access_size = 2'b00;
    assign bus.i_rvalid        = rvalid_r & (owner_r == PORT_FETCH);
    assign bus.d_rvalid        = rvalid_r & (owner_r == PORT_DATA);
    assign bus.i_rdata         = bus.i_rvalid ? bus.mem_data_out : {data_width{1'b0}};
    assign bus.d_rdata         = bus.d_rvalid ? bus.mem_data_out : {data_width{1'b0}};
    assign bus.d_wack          = accept_s & (owner_r == PORT_DATA) & ~rw_r;
    assign bus.i_done          = (state_r == DONE) & (owner_r == PORT_FETCH);
    assign bus.d_done          = (state_r == DONE) & (owner_r == PORT_DATA);
endmodule
